// File: rtl/huffman_seq_ctrl.sv
// Sequencer for the huffman encoder datapath: receive burst, NUM_SYM-1 sort/merge rounds, split pass.
// Each wait on the datapath is watchdogged; a stall sets err and parks the FSM in DONE.
module huffman_seq_ctrl #(
  parameter int NUM_SYM      = 6,
  parameter int CNT_W        = 8,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gray_valid,
  input  logic             sort_done,
  input  logic             split_done,
  output logic             CNT_valid,
  output logic             sort_start,
  output logic             merge_en,
  output logic [2:0]       merge_round,
  output logic             split_start,
  output logic             code_valid,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] rx_count
);

  // state | meaning: IDLE await burst, RECV counting, CNT_OUT counts final, SORT/SORT_WAIT sort round,
  // MERGE merge two smallest, SPLIT/SPLIT_WAIT code split, CODE_OUT codes final, DONE terminal
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    RECV       = 4'd1,
    CNT_OUT    = 4'd2,
    SORT       = 4'd3,
    SORT_WAIT  = 4'd4,
    MERGE      = 4'd5,
    SPLIT      = 4'd6,
    SPLIT_WAIT = 4'd7,
    CODE_OUT   = 4'd8,
    DONE       = 4'd9
  } state_t;

  localparam int            WD_W       = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(WAIT_TIMEOUT - 1);
  localparam logic [2:0]    LAST_ROUND = 3'(NUM_SYM - 2);

  state_t            state_q, state_d;
  logic [2:0]        round_q, round_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      round_q <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  // Symbol count only advances while the burst can still be in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_count <= '0;
    end else if (gray_valid && (state_q == IDLE || state_q == RECV) && rx_count != '1) begin
      rx_count <= rx_count + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      IDLE:     if (gray_valid) state_d = RECV;
      RECV:     if (!gray_valid) state_d = CNT_OUT;
      CNT_OUT:  state_d = SORT;
      SORT: begin
        wd_d    = '0;
        state_d = SORT_WAIT;
      end
      SORT_WAIT: begin
        if (sort_done) begin
          state_d = MERGE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      MERGE: begin
        if (round_q == LAST_ROUND) begin
          state_d = SPLIT;
        end else begin
          round_d = round_q + 3'd1;
          state_d = SORT;
        end
      end
      SPLIT: begin
        wd_d    = '0;
        state_d = SPLIT_WAIT;
      end
      SPLIT_WAIT: begin
        if (split_done) begin
          state_d = CODE_OUT;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      CODE_OUT: state_d = DONE;
      DONE:     state_d = DONE;
      default:  state_d = IDLE;
    endcase
  end

  assign CNT_valid   = (state_q == CNT_OUT);
  assign sort_start  = (state_q == SORT);
  assign merge_en    = (state_q == MERGE);
  assign split_start = (state_q == SPLIT);
  assign code_valid  = (state_q == CODE_OUT);
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign merge_round = round_q;
  assign err         = err_q;

endmodule

// File: tb/tb_huffman_seq_ctrl.sv
// Directed bench for huffman_seq_ctrl: table of frame scenarios plus a mid-operation reset sequence.
module tb_huffman_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       gray_valid = 1'b0;
  logic       sort_done = 1'b0;
  logic       split_done = 1'b0;
  logic       CNT_valid, sort_start, merge_en, split_start, code_valid, busy, err;
  logic [2:0] merge_round;
  logic [7:0] rx_count;
  logic [17:0] out_vec;

  huffman_seq_ctrl dut (
    .clk(clk), .reset(reset), .gray_valid(gray_valid), .sort_done(sort_done),
    .split_done(split_done), .CNT_valid(CNT_valid), .sort_start(sort_start),
    .merge_en(merge_en), .merge_round(merge_round), .split_start(split_start),
    .code_valid(code_valid), .busy(busy), .err(err), .rx_count(rx_count)
  );

  assign out_vec = {CNT_valid, sort_start, merge_en, merge_round, split_start,
                    code_valid, busy, err, rx_count};

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state
  int n_cnt, n_sort, n_merge, n_split, n_code, cnt_cyc, code_cyc, mr_bad, busy_at_code;
  // Responder state
  bit resp_en = 1'b0;
  int s_dly, slow_round, slow_dly, p_dly;
  int s_cnt, s_cur, s_rnd, p_cnt, p_cur;

  typedef struct {
    int n; int sd; int slow; int sdl; int pd; bit noise;
    int rx; int lat; int err; int merges; int sorts; int splits; int mr_end;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (CNT_valid) begin n_cnt++; cnt_cyc = cyc; end
      if (sort_start) n_sort++;
      if (split_start) n_split++;
      if (merge_en) begin
        if (int'(merge_round) != n_merge) mr_bad++;
        n_merge++;
      end
      if (code_valid) begin n_code++; code_cyc = cyc; busy_at_code = int'(busy); end
    end
  end

  // Datapath model: done rises a configurable number of wait cycles after each start pulse.
  initial forever begin
    @(negedge clk);
    if (resp_en) begin
      if (sort_start) begin
        s_cnt = 0;
        s_cur = (s_rnd == slow_round) ? slow_dly : s_dly;
        s_rnd++;
      end else s_cnt++;
      sort_done = (s_cnt >= s_cur);
      if (split_start) begin
        p_cnt = 0;
        p_cur = p_dly;
      end else p_cnt++;
      split_done = (p_cnt >= p_cur);
    end
  end

  task automatic reset_tb();
    n_cnt = 0; n_sort = 0; n_merge = 0; n_split = 0; n_code = 0;
    cnt_cyc = 0; code_cyc = 0; mr_bad = 0; busy_at_code = 0;
    s_cnt = 0; s_cur = 99; s_rnd = 0; p_cnt = 0; p_cur = 99;
  endtask

  task automatic apply_reset(input string name);
    @(negedge clk);
    resp_en = 1'b0; gray_valid = 1'b0; sort_done = 1'b0; split_done = 1'b0;
    reset = 1'b1;
    #1 chk(name, int'(out_vec), 0);
    @(negedge clk);
    reset_tb();
    reset = 1'b0;
  endtask

  task automatic run_scenario(input int idx, input vec_t v);
    int k;
    int lat;
    s_dly = v.sd; slow_round = v.slow; slow_dly = v.sdl; p_dly = v.pd;
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      gray_valid = 1'b1; sort_done = 1'b1; split_done = 1'b1;
    end
    @(negedge clk);
    gray_valid = 1'b0; sort_done = 1'b0; split_done = 1'b0; resp_en = 1'b1;
    for (k = 0; k < 800; k++) begin
      @(negedge clk);
      if (v.noise) gray_valid = 1'($urandom_range(0, 1));
      if (n_cnt > 0 && !busy) break;
    end
    gray_valid = 1'b0;
    if (k >= 800) chk($sformatf("v%0d_reach_done", idx), 0, 1);
    lat = (n_code > 0) ? (code_cyc - cnt_cyc) : -1;
    chk($sformatf("v%0d_rx_count", idx), int'(rx_count), v.rx);
    chk($sformatf("v%0d_cnt_valid_pulses", idx), n_cnt, 1);
    chk($sformatf("v%0d_sort_starts", idx), n_sort, v.sorts);
    chk($sformatf("v%0d_merges", idx), n_merge, v.merges);
    chk($sformatf("v%0d_split_starts", idx), n_split, v.splits);
    chk($sformatf("v%0d_code_pulses", idx), n_code, (v.lat >= 0) ? 1 : 0);
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    chk($sformatf("v%0d_err", idx), int'(err), v.err);
    chk($sformatf("v%0d_round_seq_bad", idx), mr_bad, 0);
    chk($sformatf("v%0d_round_end", idx), int'(merge_round), v.mr_end);
    if (v.lat >= 0) chk($sformatf("v%0d_busy_at_code", idx), busy_at_code, 1);
    // Spurious inputs in DONE must not disturb anything.
    resp_en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      gray_valid = 1'b1; sort_done = 1'b1; split_done = 1'b1;
    end
    @(negedge clk);
    gray_valid = 1'b0; sort_done = 1'b0; split_done = 1'b0;
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d_done_rx_hold", idx), int'(rx_count), v.rx);
    chk($sformatf("v%0d_done_err_hold", idx), int'(err), v.err);
    chk($sformatf("v%0d_done_busy", idx), int'(busy), 0);
    chk($sformatf("v%0d_done_no_code", idx), n_code, (v.lat >= 0) ? 1 : 0);
    chk($sformatf("v%0d_done_no_sort", idx), n_sort, v.sorts);
  endtask

  initial begin
    vec_t v_after;
    bit found;
    //          n   sd slow sdl pd noise rx  lat err mg so sp mr
    vecs[0] = '{10, 1, -1,  0,  1, 1'b0, 10, 18, 0, 5, 5, 1, 4};
    vecs[1] = '{4,  3, -1,  0,  1, 1'b0, 4,  28, 0, 5, 5, 1, 4};
    vecs[2] = '{5,  1,  2, 99,  1, 1'b0, 5,  -1, 1, 2, 3, 0, 2};
    vecs[3] = '{7,  1,  1, 16,  1, 1'b0, 7,  33, 0, 5, 5, 1, 4};
    vecs[4] = '{7,  1,  1, 17,  1, 1'b0, 7,  -1, 1, 1, 2, 0, 1};
    vecs[5] = '{3,  2, -1,  0, 99, 1'b0, 3,  -1, 1, 5, 5, 1, 4};
    vecs[6] = '{3,  1, -1,  0,  3, 1'b1, 3,  20, 0, 5, 5, 1, 4};
    vecs[7] = '{300, 1, -1, 0,  1, 1'b0, 255, 18, 0, 5, 5, 1, 4};
    v_after = '{4,  1, -1,  0,  1, 1'b0, 4,  18, 0, 5, 5, 1, 4};

    reset_tb();
    for (int i = 0; i < 8; i++) begin
      apply_reset($sformatf("v%0d_reset_outputs", i));
      run_scenario(i, vecs[i]);
    end

    // Reset asserted in the middle of round 3's sort wait.
    apply_reset("mid_reset_initial");
    s_dly = 5; slow_round = -1; slow_dly = 0; p_dly = 1;
    repeat (6) begin
      @(negedge clk);
      gray_valid = 1'b1;
    end
    @(negedge clk);
    gray_valid = 1'b0; resp_en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (sort_start && merge_round == 3'd3) found = 1'b1;
    end
    chk("mid_reach_round3", int'(found), 1);
    @(negedge clk);
    chk("mid_in_wait_busy", int'(busy), 1);
    resp_en = 1'b0; sort_done = 1'b0; split_done = 1'b0;
    reset = 1'b1;
    #1 chk("mid_reset_outputs", int'(out_vec), 0);
    @(negedge clk);
    chk("mid_reset_hold", int'(out_vec), 0);
    reset_tb();
    reset = 1'b0;
    run_scenario(8, v_after);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
